exclusive_max_sync: RTL and testbench

- Clocked race-logic primitive implementing exclusive-max on two event inputs.
- The output event `q` fires when the later of `a` and `b` arrives, but only if the two arrivals fall in different clock cycles.
- A tie (both in the same cycle) or a single arrival produces no output.
- Used in temporal (space-time) compute fabrics: each computation window is opened by `set`, and `q` is a step that holds until the next `set`.

---
 rtl/exclusive_max_sync_pkg.sv | 48 ++++
 rtl/exclusive_max_sync_if.sv | 22 ++
 rtl/exclusive_max_sync_event_detect.sv | 30 +++
 rtl/exclusive_max_sync.sv | 58 +++++
 tb/tb_exclusive_max_sync.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/exclusive_max_sync_pkg.sv
// Shared types and level constants for the exclusive-max race-logic block.
// Build option: define EXCLUSIVE_MAX_FALLING_EN to use falling-edge events
// (idle level 1, active level 0); otherwise events are rising edges.
package exclusive_max_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_SEEN = 3'd1,
    B_SEEN = 3'd2,
    FIRED  = 3'd3,
    TIE    = 3'd4
  } xmax_state_t;

`ifdef EXCLUSIVE_MAX_FALLING_EN
  localparam logic IDLE_LVL = 1'b1;
  localparam logic ACT_LVL  = 1'b0;
`else
  localparam logic IDLE_LVL = 1'b0;
  localparam logic ACT_LVL  = 1'b1;
`endif

  // Window transition on arrival pulses; FIRED and TIE absorb everything.
  function automatic xmax_state_t xmax_next(input xmax_state_t cur,
                                            input logic arr_a,
                                            input logic arr_b);
    xmax_state_t nxt;
    nxt = cur;
    case (cur)
      IDLE: begin
        if (arr_a && arr_b)  nxt = TIE;
        else if (arr_a)      nxt = A_SEEN;
        else if (arr_b)      nxt = B_SEEN;
      end
      A_SEEN:  if (arr_b) nxt = FIRED;
      B_SEEN:  if (arr_a) nxt = FIRED;
      FIRED:   nxt = FIRED;
      TIE:     nxt = TIE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  // Moore output level for a given window state.
  function automatic logic xmax_q_level(input xmax_state_t st);
    return (st == FIRED) ? ACT_LVL : IDLE_LVL;
  endfunction

endpackage

// File: rtl/exclusive_max_sync_if.sv
// Event bus of the exclusive-max block: window restart, two event inputs
// and the step output.
interface exclusive_max_sync_if;
  logic set;
  logic a;
  logic b;
  logic q;

  modport master (
    output set,
    output a,
    output b,
    input  q
  );

  modport slave (
    input  set,
    input  a,
    input  b,
    output q
  );
endinterface

// File: rtl/exclusive_max_sync_event_detect.sv
// Single-input event detector: sample register, delay register and a
// one-cycle arrival pulse on an idle-to-active transition.
module event_detect
  import exclusive_max_pkg::*;
#(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic aclk,
  input  logic grst,
  input  logic din,
  output logic arrive
);

  logic x_r;
  logic x_d;

  // Sample the input and keep one cycle of history; reset to idle level.
  always_ff @(posedge aclk) begin
    if (!grst) begin
      x_r <= IDLE_VAL;
      x_d <= IDLE_VAL;
    end else begin
      x_r <= din;
      x_d <= x_r;
    end
  end

  assign arrive = (x_r != IDLE_VAL) && (x_d == IDLE_VAL);

endmodule

// File: rtl/exclusive_max_sync.sv
// Exclusive-max race-logic primitive: q steps to the active level one edge
// after the later of a/b arrives, provided a and b arrived on different
// edges. A window is reopened by set.
// Build option: EXCLUSIVE_MAX_FALLING_EN selects falling-edge events.
module exclusive_max_sync
  import exclusive_max_pkg::*;
(
  input  logic                 aclk,
  input  logic                 grst,
  exclusive_max_sync_if.slave  bus
);

  logic        arr_a;
  logic        arr_b;
  logic        set_p1;
  logic        q_r;
  xmax_state_t state;
  xmax_state_t nxt;

  event_detect #(.IDLE_VAL(IDLE_LVL)) u_det_a (
    .aclk   (aclk),
    .grst   (grst),
    .din    (bus.a),
    .arrive (arr_a)
  );

  event_detect #(.IDLE_VAL(IDLE_LVL)) u_det_b (
    .aclk   (aclk),
    .grst   (grst),
    .din    (bus.b),
    .arrive (arr_b)
  );

  assign nxt = xmax_next(state, arr_a, arr_b);

  // Window FSM with registered Moore output. The pulse seen in the cycle
  // after set comes from the sample taken while set was high, so it is
  // dropped too: only samples after set released open the new window.
  always_ff @(posedge aclk) begin
    if (!grst) begin
      state  <= IDLE;
      q_r    <= IDLE_LVL;
      set_p1 <= 1'b0;
    end else begin
      set_p1 <= bus.set;
      if (bus.set) begin
        state <= IDLE;
        q_r   <= IDLE_LVL;
      end else if (!set_p1) begin
        state <= nxt;
        q_r   <= xmax_q_level(nxt);
      end
    end
  end

  assign bus.q = q_r;

endmodule

// File: tb/tb_exclusive_max_sync.sv
// Randomized and directed bench for exclusive_max_sync. The reference model
// records, per window, the edge at which each input is first sampled at the
// active level and predicts q from those two edge numbers.
module tb_exclusive_max_sync;
  import exclusive_max_pkg::*;

  logic aclk = 1'b0;
  logic grst;
  always #5 aclk = ~aclk;

  exclusive_max_sync_if bus_i ();

  exclusive_max_sync dut (
    .aclk (aclk),
    .grst (grst),
    .bus  (bus_i)
  );

  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  logic prev_a, prev_b;
  int   ta, tb;

  task automatic check_q(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: q=%b expected %b at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  // q is active once both first arrivals are known, differ, and the later
  // one happened at least one edge ago.
  function automatic logic model_q();
    int later;
    if (ta < 0 || tb < 0 || ta == tb) return IDLE_LVL;
    later = (ta > tb) ? ta : tb;
    return (later < edge_n) ? ACT_LVL : IDLE_LVL;
  endfunction

  task automatic tick(input string tag);
    logic ev_a, ev_b;
    @(posedge aclk);
    edge_n++;
    if (!grst) begin
      prev_a = IDLE_LVL;
      prev_b = IDLE_LVL;
      ta = -1;
      tb = -1;
    end else begin
      ev_a = (bus_i.a == ACT_LVL) && (prev_a == IDLE_LVL);
      ev_b = (bus_i.b == ACT_LVL) && (prev_b == IDLE_LVL);
      prev_a = bus_i.a;
      prev_b = bus_i.b;
      if (bus_i.set) begin
        ta = -1;
        tb = -1;
      end else begin
        if (ev_a && ta < 0) ta = edge_n;
        if (ev_b && tb < 0) tb = edge_n;
      end
    end
    #1;
    check_q(tag, bus_i.q, model_q());
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic set_pulse();
    bus_i.set = 1'b1;
    tick("set");
    bus_i.set = 1'b0;
  endtask

  initial begin
    grst = 1'b0;
    bus_i.set = 1'b0;
    bus_i.a = IDLE_LVL;
    bus_i.b = IDLE_LVL;
    prev_a = IDLE_LVL;
    prev_b = IDLE_LVL;
    ta = -1;
    tb = -1;

    run(3, "reset");
    check_q("reset_level", bus_i.q, IDLE_LVL);
    grst = 1'b1;

    // Idle window
    set_pulse();
    run(40, "idle_window");

    // a before b
    set_pulse();
    run(9, "ab_wait");
    bus_i.a = ACT_LVL;
    run(10, "ab_first");
    bus_i.b = ACT_LVL;
    tick("ab_second");
    check_q("ab_not_yet", bus_i.q, IDLE_LVL);
    tick("ab_fire");
    check_q("ab_fired", bus_i.q, ACT_LVL);
    run(5, "ab_hold");
    set_pulse();
    check_q("ab_set_clears", bus_i.q, IDLE_LVL);
    bus_i.a = IDLE_LVL;
    bus_i.b = IDLE_LVL;
    run(3, "ab_release");

    // b before a, then swaps and repeats
    set_pulse();
    run(9, "ba_wait");
    bus_i.b = ACT_LVL;
    run(10, "ba_first");
    bus_i.a = ACT_LVL;
    run(2, "ba_fire");
    check_q("ba_fired", bus_i.q, ACT_LVL);
    for (int i = 0; i < 6; i++) begin
      bus_i.a = (i % 2 == 0) ? IDLE_LVL : ACT_LVL;
      bus_i.b = (i % 2 == 0) ? ACT_LVL : IDLE_LVL;
      run(3, "ba_repeat");
    end
    check_q("ba_held", bus_i.q, ACT_LVL);
    bus_i.a = IDLE_LVL;
    bus_i.b = IDLE_LVL;
    set_pulse();
    run(3, "ba_release");

    // Tie
    set_pulse();
    run(9, "tie_wait");
    bus_i.a = ACT_LVL;
    bus_i.b = ACT_LVL;
    run(30, "tie_hold");
    check_q("tie_idle", bus_i.q, IDLE_LVL);
    bus_i.a = IDLE_LVL;
    run(3, "tie_toggle");
    bus_i.a = ACT_LVL;
    run(5, "tie_toggle");
    check_q("tie_absorbing", bus_i.q, IDLE_LVL);
    bus_i.a = IDLE_LVL;
    bus_i.b = IDLE_LVL;
    set_pulse();
    run(3, "tie_release");

    // b arrives during set, a arrives later: only a counts
    bus_i.set = 1'b1;
    bus_i.b = ACT_LVL;
    tick("setprio_set");
    bus_i.set = 1'b0;
    run(5, "setprio_gap");
    bus_i.a = ACT_LVL;
    run(10, "setprio_a");
    check_q("setprio_no_fire", bus_i.q, IDLE_LVL);
    // a fresh b arrival proves the window sits in A_SEEN
    bus_i.b = IDLE_LVL;
    run(2, "setprio_b_low");
    bus_i.b = ACT_LVL;
    run(2, "setprio_b_high");
    check_q("setprio_a_seen_fires", bus_i.q, ACT_LVL);

    // Reset while fired, with set high at the same time
    grst = 1'b0;
    bus_i.set = 1'b1;
    tick("grst_fired");
    check_q("grst_clears", bus_i.q, IDLE_LVL);
    grst = 1'b1;
    bus_i.set = 1'b0;
    bus_i.a = IDLE_LVL;
    bus_i.b = IDLE_LVL;
    run(3, "grst_release");

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bus_i.set = ($urandom_range(0, 39) == 0);
      grst = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 7) == 0) bus_i.a = ~bus_i.a;
      if ($urandom_range(0, 7) == 0) bus_i.b = ~bus_i.b;
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
